// File: rtl/vga_pkg.sv
// Shared VGA pixel-pipeline widths and sprite geometry.
package vga_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 11;
    localparam int RGB_W  = 12;
    localparam int POS_W  = 12;
    // One bit wider than POS_W so hcount - xpos never wraps.
    localparam int DIFF_W = 13;
    localparam int SPR_W  = 32;
    localparam int SPR_H  = 32;
    localparam int ROM_AW = 10;

    typedef struct packed {
        logic [HCNT_W-1:0] hcount;
        logic [VCNT_W-1:0] vcount;
        logic              hsync;
        logic              vsync;
        logic              hblnk;
        logic              vblnk;
    } vga_timing_t;

endpackage

// File: rtl/sprite_pos_latch.sv
// Holds the pending and active sprite position; the active one only
// changes on a rising edge of vertical blank so a frame is never torn.
module sprite_pos_latch
    import vga_pkg::*;
#(
    parameter logic [POS_W-1:0] X_RESET = '0,
    parameter logic [POS_W-1:0] Y_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] xpos,
    input  logic [POS_W-1:0] ypos,
    input  logic             pos_valid,
    input  logic             vblnk_in,
    output logic [POS_W-1:0] xact,
    output logic [POS_W-1:0] yact
);

    logic [POS_W-1:0] xpend_q, xpend_d;
    logic [POS_W-1:0] ypend_q, ypend_d;
    logic [POS_W-1:0] xact_q, xact_d;
    logic [POS_W-1:0] yact_q, yact_d;
    logic             pend_q, pend_d;
    logic             vblnk_prev_q, vblnk_prev_d;
    logic             vblnk_rise;

    // Next-state: capture requests, promote on vblank rise (fresh strobe wins).
    always_comb begin
        xpend_d      = xpend_q;
        ypend_d      = ypend_q;
        xact_d       = xact_q;
        yact_d       = yact_q;
        pend_d       = pend_q;
        vblnk_prev_d = vblnk_in;
        vblnk_rise   = vblnk_in & ~vblnk_prev_q;

        if (pos_valid) begin
            xpend_d = xpos;
            ypend_d = ypos;
            pend_d  = 1'b1;
        end

        if (vblnk_rise && (pend_q || pos_valid)) begin
            xact_d = pos_valid ? xpos : xpend_q;
            yact_d = pos_valid ? ypos : ypend_q;
            pend_d = 1'b0;
        end
    end

    // Position registers with async reset to the configured start point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpend_q      <= '0;
            ypend_q      <= '0;
            xact_q       <= X_RESET;
            yact_q       <= Y_RESET;
            pend_q       <= 1'b0;
            vblnk_prev_q <= 1'b0;
        end else begin
            xpend_q      <= xpend_d;
            ypend_q      <= ypend_d;
            xact_q       <= xact_d;
            yact_q       <= yact_d;
            pend_q       <= pend_d;
            vblnk_prev_q <= vblnk_prev_d;
        end
    end

    assign xact = xact_q;
    assign yact = yact_q;

endmodule

// File: rtl/draw_sprite_32x32.sv
// Overlays a 32x32 sprite on the VGA stream. Three register stages:
// S1 issues the ROM address, S2 waits for the registered ROM, S3 mixes.
module draw_sprite_32x32
    import vga_pkg::*;
#(
    parameter int               IMG_WIDTH  = SPR_W,
    parameter int               IMG_HEIGHT = SPR_H,
    parameter bit               KEY_EN     = 1'b1,
    parameter logic [RGB_W-1:0] KEY_COLOR  = 12'hF0F,
    parameter logic [POS_W-1:0] X_RESET    = 12'd0,
    parameter logic [POS_W-1:0] Y_RESET    = 12'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HCNT_W-1:0] hcount_in,
    input  logic [VCNT_W-1:0] vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [POS_W-1:0]  xpos,
    input  logic [POS_W-1:0]  ypos,
    input  logic              pos_valid,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [RGB_W-1:0]  rom_pixel,
    output logic [HCNT_W-1:0] hcount_out,
    output logic [VCNT_W-1:0] vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);

    localparam int XB = $clog2(IMG_WIDTH);
    localparam int YB = $clog2(IMG_HEIGHT);

    logic [POS_W-1:0]  xact, yact;
    logic [DIFF_W-1:0] dx, dy;
    logic              hit_s0;
    logic              key_match;
    vga_timing_t       tim_s0;

    vga_timing_t       tim_d1_q, tim_d1_d;
    vga_timing_t       tim_d2_q, tim_d2_d;
    vga_timing_t       tim_out_q, tim_out_d;
    logic [RGB_W-1:0]  rgb_d1_q, rgb_d1_d;
    logic [RGB_W-1:0]  rgb_d2_q, rgb_d2_d;
    logic [RGB_W-1:0]  rgb_out_q, rgb_out_d;
    logic              hit_d1_q, hit_d1_d;
    logic              hit_d2_q, hit_d2_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

    sprite_pos_latch #(
        .X_RESET (X_RESET),
        .Y_RESET (Y_RESET)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .xpos      (xpos),
        .ypos      (ypos),
        .pos_valid (pos_valid),
        .vblnk_in  (vblnk_in),
        .xact      (xact),
        .yact      (yact)
    );

    // Hit test, address generation and the three pipeline stages' next values.
    always_comb begin
        tim_s0 = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                   vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

        // Negative offsets become large unsigned values and fail the compare,
        // so sprites left of / above the beam or off-screen clip cleanly.
        dx = DIFF_W'(hcount_in) - DIFF_W'(xact);
        dy = DIFF_W'(vcount_in) - DIFF_W'(yact);
        hit_s0 = (dx < DIFF_W'(IMG_WIDTH)) && (dy < DIFF_W'(IMG_HEIGHT)) &&
                 !hblnk_in && !vblnk_in;

        rom_addr_d = hit_s0 ? ROM_AW'({dy[YB-1:0], dx[XB-1:0]}) : '0;
        tim_d1_d   = tim_s0;
        rgb_d1_d   = rgb_in;
        hit_d1_d   = hit_s0;

        tim_d2_d   = tim_d1_q;
        rgb_d2_d   = rgb_d1_q;
        hit_d2_d   = hit_d1_q;

        key_match  = KEY_EN && (rom_pixel == KEY_COLOR);
        tim_out_d  = tim_d2_q;
        rgb_out_d  = (hit_d2_q && !key_match) ? rom_pixel : rgb_d2_q;
    end

    // Pipeline registers; reset flushes every stage to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            tim_d1_q   <= '0;
            rgb_d1_q   <= '0;
            hit_d1_q   <= 1'b0;
            tim_d2_q   <= '0;
            rgb_d2_q   <= '0;
            hit_d2_q   <= 1'b0;
            tim_out_q  <= '0;
            rgb_out_q  <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            tim_d1_q   <= tim_d1_d;
            rgb_d1_q   <= rgb_d1_d;
            hit_d1_q   <= hit_d1_d;
            tim_d2_q   <= tim_d2_d;
            rgb_d2_q   <= rgb_d2_d;
            hit_d2_q   <= hit_d2_d;
            tim_out_q  <= tim_out_d;
            rgb_out_q  <= rgb_out_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign hcount_out = tim_out_q.hcount;
    assign vcount_out = tim_out_q.vcount;
    assign hsync_out  = tim_out_q.hsync;
    assign vsync_out  = tim_out_q.vsync;
    assign hblnk_out  = tim_out_q.hblnk;
    assign vblnk_out  = tim_out_q.vblnk;
    assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_draw_sprite_32x32.sv
// Scoreboard bench for draw_sprite_32x32 with a registered sprite-ROM model.
module tb_draw_sprite_32x32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
    logic        pos_valid = 1'b0;
    logic [9:0]  rom_addr;
    logic [11:0] rom_pixel = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int compared = 0;
    int mismatched = 0;

    logic [37:0] exp_q[$];
    logic [9:0]  addr_exp;
    bit          addr_vld = 0;
    int          m_xact = 0, m_yact = 0, m_xpend = 0, m_ypend = 0;
    bit          m_pend = 0, m_vprev = 0;

    draw_sprite_32x32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .pos_valid  (pos_valid),
        .rom_addr   (rom_addr),
        .rom_pixel  (rom_pixel),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    always #5 clk = ~clk;

    // Sprite contents: 0x800|addr everywhere, except the key colour at the last texel.
    function automatic logic [11:0] rom_fn(input logic [9:0] a);
        return (a == 10'h3FF) ? 12'hF0F : (12'h800 | {2'b00, a});
    endfunction

    always @(posedge clk) rom_pixel <= rom_fn(rom_addr);

    wire [37:0] out_vec = {hcount_out, vcount_out, hsync_out, vsync_out,
                           hblnk_out, vblnk_out, rgb_out};

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_px(input int h, input int v, input logic hs, input logic vs,
                            input logic hb, input logic vb, input logic [11:0] rgb,
                            input logic pv, input int x, input int y);
        int          dx, dy;
        bit          hit;
        logic [9:0]  a;
        logic [11:0] pix, rgb_e;
        @(negedge clk);
        if (addr_vld) check("rom_addr", 38'(rom_addr), 38'(addr_exp));
        if (exp_q.size() >= 3) check("pixel_out", out_vec, exp_q.pop_front());
        hcount_in = 11'(h); vcount_in = 11'(v);
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
        rgb_in = rgb; pos_valid = pv; xpos = 12'(x); ypos = 12'(y);
        dx  = h - m_xact;
        dy  = v - m_yact;
        hit = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32) && !hb && !vb;
        a   = hit ? 10'(dy * 32 + dx) : 10'd0;
        pix = rom_fn(a);
        rgb_e = (hit && pix != 12'hF0F) ? pix : rgb;
        exp_q.push_back({11'(h), 11'(v), hs, vs, hb, vb, rgb_e});
        addr_exp = a;
        addr_vld = 1;
        if (pv) begin m_xpend = x; m_ypend = y; m_pend = 1; end
        if (vb && !m_vprev && (m_pend || pv)) begin
            m_xact = pv ? x : m_xpend;
            m_yact = pv ? y : m_ypend;
            m_pend = 0;
        end
        m_vprev = vb;
    endtask

    task automatic px(input int h, input int v, input logic [11:0] rgb);
        drive_px(h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb, 1'b0, 0, 0);
    endtask

    task automatic load_pos(input int x, input int y);
        drive_px(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, x, y);
    endtask

    task automatic vblank(input logic pv, input int x, input int y);
        drive_px(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 0, 0);
        drive_px(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, pv, x, y);
        drive_px(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 0, 0);
        drive_px(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 0, 0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst_n = 1'b0; hblnk_in = 1'b1; vblnk_in = 1'b0; pos_valid = 1'b0;
        #1;
        check("midreset_outputs", out_vec, 38'd0);
        check("midreset_rom_addr", 38'(rom_addr), 38'd0);
        exp_q.delete();
        addr_vld = 0;
        m_xact = 0; m_yact = 0; m_xpend = 0; m_ypend = 0; m_pend = 0; m_vprev = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        check("reset_outputs", out_vec, 38'd0);
        check("reset_rom_addr", 38'(rom_addr), 38'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_rom_addr", 38'(rom_addr), 38'd0);

        // Reset position (0,0): drawing starts at hcount 0.
        px(0, 0, 12'h111);
        px(31, 0, 12'h111);
        px(32, 0, 12'h111);
        px(5, 31, 12'h111);
        px(5, 32, 12'h111);

        // Address and edges around (100,50).
        load_pos(100, 50);
        vblank(1'b0, 0, 0);
        px(103, 52, 12'h222);
        @(posedge clk); #1;
        check("addr_043", 38'(rom_addr), 38'h043);
        px(99, 52, 12'h333);
        px(100, 52, 12'h333);
        px(131, 52, 12'h333);
        px(132, 52, 12'h333);
        px(103, 49, 12'h444);
        px(103, 50, 12'h444);
        px(103, 81, 12'h444);
        px(103, 82, 12'h444);

        // Colour key: last texel is transparent, (128,71) maps to 0xABC.
        px(131, 81, 12'h123);
        px(128, 71, 12'h123);

        // Mid-frame position request waits for the next vblank rise.
        load_pos(200, 10);
        px(103, 52, 12'h555);
        px(203, 12, 12'h555);
        vblank(1'b0, 0, 0);
        px(203, 12, 12'h555);
        px(103, 52, 12'h555);
        vblank(1'b1, 300, 20);
        px(300, 20, 12'h666);
        px(203, 12, 12'h666);
        load_pos(400, 400);
        vblank(1'b1, 500, 30);
        px(500, 30, 12'h777);
        px(400, 400, 12'h777);

        // Clipping near the bottom-right corner of an 800x600 screen.
        load_pos(790, 590);
        vblank(1'b0, 0, 0);
        px(795, 595, 12'h0A0);
        px(799, 599, 12'h0A0);
        px(0, 595, 12'h0A0);
        px(5, 595, 12'h0A0);
        px(795, 5, 12'h0A0);
        drive_px(800, 595, 1'b1, 1'b0, 1'b1, 1'b0, 12'h0A0, 1'b0, 0, 0);
        drive_px(795, 600, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0A0, 1'b0, 0, 0);

        // Reset mid-line flushes the pipeline and restores position (0,0).
        px(795, 595, 12'h0B0);
        px(796, 595, 12'h0B0);
        reset_mid();
        px(0, 0, 12'h0C0);
        px(40, 0, 12'h0C0);

        // Random timing/colour traffic with occasional position updates.
        for (int i = 0; i < 300; i++) begin
            drive_px(int'($urandom_range(80, 140)), int'($urandom_range(30, 90)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                     12'($urandom), ($urandom_range(0, 15) == 0),
                     int'($urandom_range(80, 120)), int'($urandom_range(30, 70)));
        end

        // Drain the pipeline.
        for (int i = 0; i < 4; i++) begin
            drive_px(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
